wb_write_arbiter: RTL and testbench

- Sole driver of the register-file write port (we3/wa3/wd3).
- Merges two producers onto that port:
  - the in-order pipeline writeback, which has no backpressure and takes priority;
  - a long-latency unit (mul/div, uncached load return) using a valid/ready handshake, buffered in a small FIFO.
- Exports pending-write hazard flags to decode and a stall request so the buffered writes cannot starve.

---
 rtl/wb_write_arbiter_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 76 +++++++
 rtl/wb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Both the long-latency FIFO and the output stage carry wb_req_t payloads.
package wb_write_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

    // Writes to r0 are architecturally discarded.
    function automatic logic is_live_wa(input logic [REG_W-1:0] wa);
        return wa != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO for long-latency write requests.
// Exposes every slot's destination and a valid mask for the hazard compare.
module wb_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_req_t                       push_req,
    input  logic                          pop,
    output wb_req_t                       head,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH*REG_W-1:0]        entry_wa,
    output logic [DEPTH-1:0]              entry_vld
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard against misuse so the pointers can never desynchronise from count.
    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop  && (count_q != CNT_W'(0));

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PTR_W-1:0] offs;
        assign offs                      = PTR_W'(g) - rd_ptr_q;
        assign entry_vld[g]              = CNT_W'(offs) < count_q;
        assign entry_wa[g*REG_W +: REG_W] = mem_q[g].wa;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sole driver of the register-file write port: pipeline writeback has priority,
// long-latency results are buffered and forced through by a starvation stall.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        pend1,
    output logic        pend2,
    output logic        stall_req,
    output logic        err_prio
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    wb_req_t                lu_req;
    wb_req_t                fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic [DEPTH*REG_W-1:0] fifo_wa;
    logic [DEPTH-1:0]       fifo_vld;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   pipe_req;
    logic [DEPTH-1:0]       hit1;
    logic [DEPTH-1:0]       hit2;

    logic              we3_q,       we3_d;
    logic [REG_W-1:0]  wa3_q,       wa3_d;
    logic [DATA_W-1:0] wd3_q,       wd3_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic              stall_req_q, stall_req_d;
    logic              err_prio_q,  err_prio_d;

    assign lu_req     = '{wa: lu_wa, wd: lu_wd};
    assign fifo_empty = (fifo_count == CNT_W'(0));
    assign lu_ready   = (fifo_count != CNT_W'(DEPTH));
    assign push       = lu_valid && lu_ready;
    assign pipe_req   = pipe_we && is_live_wa(pipe_wa);
    assign pop        = !pipe_req && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_req  (lu_req),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .entry_wa  (fifo_wa),
        .entry_vld (fifo_vld)
    );

    // Output register is not checked: it commits on the negedge before decode reads.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pend
        assign hit1[g] = fifo_vld[g] && (fifo_wa[g*REG_W +: REG_W] == ra1);
        assign hit2[g] = fifo_vld[g] && (fifo_wa[g*REG_W +: REG_W] == ra2);
    end

    assign pend1 = is_live_wa(ra1) && (|hit1);
    assign pend2 = is_live_wa(ra2) && (|hit2);

    always_comb begin
        we3_d       = 1'b0;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        wait_d      = wait_q;
        stall_req_d = (wait_q >= WAIT_W'(MAX_WAIT));
        err_prio_d  = err_prio_q || (pipe_we && stall_req_q);

        if (pipe_req) begin
            we3_d = 1'b1;
            wa3_d = pipe_wa;
            wd3_d = pipe_wd;
        end else if (pop) begin
            we3_d = is_live_wa(fifo_head.wa);
            wa3_d = fifo_head.wa;
            wd3_d = fifo_head.wd;
        end

        // Counts cycles the head sat in the FIFO without draining.
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q       <= 1'b0;
            wa3_q       <= '0;
            wd3_q       <= '0;
            wait_q      <= '0;
            stall_req_q <= 1'b0;
            err_prio_q  <= 1'b0;
        end else begin
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            wait_q      <= wait_d;
            stall_req_q <= stall_req_d;
            err_prio_q  <= err_prio_d;
        end
    end

    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign stall_req = stall_req_q;
    assign err_prio  = err_prio_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
    logic        err_prio;

    int n_checks = 0;
    int n_fail   = 0;

    wb_write_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_we   (pipe_we),
        .pipe_wa   (pipe_wa),
        .pipe_wd   (pipe_wd),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_wa     (lu_wa),
        .lu_wd     (lu_wd),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .pend1     (pend1),
        .pend2     (pend2),
        .stall_req (stall_req),
        .err_prio  (err_prio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        pipe_we  = 1'b0;
        pipe_wa  = 5'd0;
        pipe_wd  = 32'h0;
        lu_valid = 1'b0;
        lu_wa    = 5'd0;
        lu_wd    = 32'h0;
        ra1      = 5'd0;
        ra2      = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_err", 32'(err_prio), 32'd0);
        rst = 1'b0;

        // Pipe-only write: visible one cycle later, then idle
        pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h1234;
        tick();
        chk("pipe_we3", 32'(we3), 32'd1);
        chk("pipe_wa3", 32'(wa3), 32'd3);
        chk("pipe_wd3", wd3, 32'h1234);
        pipe_we = 1'b0;
        tick();
        chk("pipe_idle_we3", 32'(we3), 32'd0);
        chk("pipe_idle_wa3_hold", 32'(wa3), 32'd3);

        // Long-latency on idle pipe: push, pending, then issue
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'hDEAD;
        #1;
        chk("lu_ready_idle", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0; ra1 = 5'd7;
        #1;
        chk("lu_pend1", 32'(pend1), 32'd1);
        chk("lu_no_same_cycle_pop", 32'(we3), 32'd0);
        tick();
        chk("lu_we3", 32'(we3), 32'd1);
        chk("lu_wa3", 32'(wa3), 32'd7);
        chk("lu_wd3", wd3, 32'hDEAD);
        chk("lu_pend1_clear", 32'(pend1), 32'd0);
        ra1 = 5'd0;
        tick();
        chk("lu_done_we3", 32'(we3), 32'd0);

        // Fill with the pipe busy every cycle
        pipe_we = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'h11;
        lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'hA0;
        #1;
        chk("fill_ready0", 32'(lu_ready), 32'd1);
        tick();                                   // push A, wait 0
        chk("fill_pipe_wa3", 32'(wa3), 32'd1);
        chk("fill_ready1", 32'(lu_ready), 32'd1);
        lu_wa = 5'd10; lu_wd = 32'hB0;
        tick();                                   // push B, wait 1
        chk("fill_ready_full", 32'(lu_ready), 32'd0);
        lu_wa = 5'd11; lu_wd = 32'hC0; pipe_wd = 32'h12;
        tick();                                   // C refused, wait 2
        chk("fill_pipe_wd3", wd3, 32'h12);
        chk("fill_still_full", 32'(lu_ready), 32'd0);
        lu_valid = 1'b0; ra1 = 5'd9; ra2 = 5'd11;
        #1;
        chk("fill_pend1_A", 32'(pend1), 32'd1);
        chk("fill_pend2_C_dropped", 32'(pend2), 32'd0);
        ra1 = 5'd0; ra2 = 5'd0;

        // Starvation: stall_req after the wait counter saturates
        tick();                                   // wait 3
        tick();                                   // wait 4
        chk("starve_stall_early", 32'(stall_req), 32'd0);
        chk("starve_pipe_we3", 32'(we3), 32'd1);
        tick();                                   // stall_req rises
        chk("starve_stall", 32'(stall_req), 32'd1);
        chk("starve_err_clear", 32'(err_prio), 32'd0);
        pipe_we = 1'b0;
        tick();                                   // head A pops
        chk("starve_pop_we3", 32'(we3), 32'd1);
        chk("starve_pop_wa3", 32'(wa3), 32'd9);
        chk("starve_pop_wd3", wd3, 32'hA0);
        chk("starve_stall_lag", 32'(stall_req), 32'd1);
        chk("starve_ready", 32'(lu_ready), 32'd1);
        pipe_we = 1'b1; pipe_wa = 5'd2; pipe_wd = 32'h22;
        tick();                                   // pipe wins during stall
        chk("prio_wa3", 32'(wa3), 32'd2);
        chk("prio_err", 32'(err_prio), 32'd1);
        chk("prio_stall_drop", 32'(stall_req), 32'd0);

        // pipe_wa==0 is no request: FIFO head B pops
        pipe_wa = 5'd0; pipe_wd = 32'h33;
        tick();
        chk("r0_pop_we3", 32'(we3), 32'd1);
        chk("r0_pop_wa3", 32'(wa3), 32'd10);
        chk("r0_pop_wd3", wd3, 32'hB0);
        chk("r0_err_sticky", 32'(err_prio), 32'd1);

        // lu_wa==0 accepted, then popped with we3 low
        pipe_we = 1'b0;
        lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'h55;
        tick();
        lu_valid = 1'b0;
        chk("lu0_push_we3", 32'(we3), 32'd0);
        chk("lu0_wa3_hold", 32'(wa3), 32'd10);
        tick();
        chk("lu0_pop_we3", 32'(we3), 32'd0);
        chk("lu0_pop_wa3", 32'(wa3), 32'd0);
        chk("lu0_pop_wd3", wd3, 32'h55);
        chk("lu0_ready", 32'(lu_ready), 32'd1);

        // Reset mid-stream with two buffered entries and we3 high
        pipe_we = 1'b1; pipe_wa = 5'd4; pipe_wd = 32'h44;
        lu_valid = 1'b1; lu_wa = 5'd12; lu_wd = 32'hC12;
        tick();
        lu_wa = 5'd13; lu_wd = 32'hC13;
        tick();
        lu_valid = 1'b0; ra1 = 5'd12; ra2 = 5'd13;
        #1;
        chk("mid_we3", 32'(we3), 32'd1);
        chk("mid_pend1", 32'(pend1), 32'd1);
        chk("mid_pend2", 32'(pend2), 32'd1);
        chk("mid_full", 32'(lu_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_we3", 32'(we3), 32'd0);
        chk("arst_ready", 32'(lu_ready), 32'd1);
        chk("arst_pend1", 32'(pend1), 32'd0);
        chk("arst_pend2", 32'(pend2), 32'd0);
        chk("arst_err", 32'(err_prio), 32'd0);
        pipe_we = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_we3", 32'(we3), 32'd0);
        chk("post_rst_ready", 32'(lu_ready), 32'd1);
        chk("post_rst_pend1", 32'(pend1), 32'd0);
        chk("post_rst_pend2", 32'(pend2), 32'd0);
        chk("post_rst_stall", 32'(stall_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
